// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller driving an SRAM-like req/addr_ok/data_ok bus.
// Optional feature macro: MEM_LWLR_EN adds LWL/LWR unaligned-load merge support.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_Flush,
   input  logic        MEM_Valid,
   input  logic [31:0] MEM_ALUOut,
   input  logic [31:0] MEM_OutB,
   input  logic        MEM_IsLoad,
   input  logic        MEM_IsStore,
   input  logic [1:0]  MEM_Size,
   input  logic        MEM_LoadSign,
   input  logic [1:0]  MEM_LWLR,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [31:0] MEM_LoadData,
   output logic        MEM_Stall,
   output logic        MEM_AdEL,
   output logic        MEM_AdES,
   output logic [31:0] MEM_BadVAddr,
   output logic [2:0]  dbg_state
);

   // Bus handshake: once data_req rises its payload stays stable until the cycle data_addr_ok
   // is seen (request never withdrawn); each accepted request gets exactly one data_data_ok.
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;
   state_t state, state_n;

   logic        is_mem, use_lwlr, aligned, acc, flush_any;
   logic        flush_pend, flush_pend_n;
   logic [1:0]  k;
   logic [1:0]  fmt_size;
   logic [31:0] fmt_addr, fmt_wdata;
   logic [3:0]  fmt_wstrb;
   logic        lat_wr, lat_sign;
   logic [1:0]  lat_size, lat_k;
   logic [31:0] lat_addr, lat_wdata;
   logic [3:0]  lat_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_fmt, load_q;

   assign k      = MEM_ALUOut[1:0];
   assign is_mem = MEM_Valid & (MEM_IsLoad | MEM_IsStore);

`ifdef MEM_LWLR_EN
   logic [1:0] lat_lwlr;
   assign use_lwlr = MEM_IsLoad & (MEM_LWLR[0] ^ MEM_LWLR[1]);
`else
   logic unused_lwlr;
   assign use_lwlr    = 1'b0;
   assign unused_lwlr = ^MEM_LWLR;
`endif

   always_comb begin
      case (MEM_Size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~k[0];
         default: aligned = (k == 2'b00);
      endcase
      if (use_lwlr) aligned = 1'b1;
   end

   assign acc          = is_mem & aligned & ~MEM_Flush;
   assign MEM_AdEL     = is_mem & ~aligned & MEM_IsLoad;
   assign MEM_AdES     = is_mem & ~aligned & MEM_IsStore;
   assign MEM_BadVAddr = MEM_ALUOut;
   assign flush_any    = MEM_Flush | flush_pend;

   // Loads keep wdata = OutB so the latched copy doubles as the LWL/LWR merge operand.
   always_comb begin
      fmt_size  = (MEM_Size == 2'd3) ? 2'd2 : MEM_Size;
      fmt_addr  = MEM_ALUOut;
      fmt_wstrb = 4'b0000;
      fmt_wdata = MEM_OutB;
      if (use_lwlr) begin
         fmt_size = 2'd2;
         fmt_addr = {MEM_ALUOut[31:2], 2'b00};
      end
      if (MEM_IsStore) begin
         case (MEM_Size)
            2'd0: begin
               fmt_wstrb = 4'b0001 << k;
               fmt_wdata = {4{MEM_OutB[7:0]}};
            end
            2'd1: begin
               fmt_wstrb = k[1] ? 4'b1100 : 4'b0011;
               fmt_wdata = {2{MEM_OutB[15:0]}};
            end
            default: fmt_wstrb = 4'b1111;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_wr    <= 1'b0;
         lat_sign  <= 1'b0;
         lat_size  <= 2'd0;
         lat_k     <= 2'd0;
         lat_addr  <= '0;
         lat_wstrb <= '0;
         lat_wdata <= '0;
      end else if (state == S_IDLE && acc) begin
         lat_wr    <= MEM_IsStore;
         lat_sign  <= MEM_LoadSign;
         lat_size  <= fmt_size;
         lat_k     <= k;
         lat_addr  <= fmt_addr;
         lat_wstrb <= fmt_wstrb;
         lat_wdata <= fmt_wdata;
      end
   end

`ifdef MEM_LWLR_EN
   always_ff @(posedge clk) begin
      if (rst)                        lat_lwlr <= 2'b00;
      else if (state == S_IDLE && acc) lat_lwlr <= use_lwlr ? MEM_LWLR : 2'b00;
   end
`endif

   assign ld_byte = data_rdata[{lat_k, 3'b000} +: 8];
   assign ld_half = lat_k[1] ? data_rdata[31:16] : data_rdata[15:0];

   always_comb begin
      case (lat_size)
         2'd0:    load_fmt = {{24{lat_sign & ld_byte[7]}}, ld_byte};
         2'd1:    load_fmt = {{16{lat_sign & ld_half[15]}}, ld_half};
         default: load_fmt = data_rdata;
      endcase
`ifdef MEM_LWLR_EN
      if (lat_lwlr == 2'b01)
         load_fmt = (data_rdata << {~lat_k, 3'b000}) |
                    (lat_wdata & (32'hFFFF_FFFF >> ({1'b0, lat_k, 3'b000} + 6'd8)));
      else if (lat_lwlr == 2'b10)
         load_fmt = (data_rdata >> {lat_k, 3'b000}) |
                    (lat_wdata & ~(32'hFFFF_FFFF >> {lat_k, 3'b000}));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_n;
         flush_pend <= flush_pend_n;
      end
   end

   always_comb begin
      state_n      = state;
      flush_pend_n = flush_pend;
      data_req     = 1'b0;
      data_wr      = lat_wr;
      data_size    = lat_size;
      data_addr    = lat_addr;
      data_wstrb   = lat_wstrb;
      data_wdata   = lat_wdata;
      MEM_Stall    = 1'b0;
      case (state)
         S_IDLE: begin
            data_req   = acc;
            data_wr    = MEM_IsStore;
            data_size  = fmt_size;
            data_addr  = fmt_addr;
            data_wstrb = fmt_wstrb;
            data_wdata = fmt_wdata;
            MEM_Stall  = acc;
            if (acc) state_n = data_addr_ok ? S_WAIT : S_REQ;
         end
         S_REQ: begin
            data_req  = 1'b1;
            MEM_Stall = 1'b1;
            if (MEM_Flush) flush_pend_n = 1'b1;
            if (data_addr_ok) state_n = flush_any ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            MEM_Stall = 1'b1;
            if (data_data_ok)   state_n = flush_any ? S_IDLE : S_DONE;
            else if (flush_any) state_n = S_DRAIN;
         end
         S_DONE: state_n = S_IDLE;
         S_DRAIN: begin
            MEM_Stall = is_mem;
            if (data_data_ok) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (state_n == S_IDLE) flush_pend_n = 1'b0;
   end

   // A flushed response or a store completion leaves the previous load result untouched.
   always_ff @(posedge clk) begin
      if (rst)
         load_q <= '0;
      else if (state == S_WAIT && data_data_ok && !flush_any && !lat_wr)
         load_q <= load_fmt;
   end

   assign MEM_LoadData = load_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a simple bus-slave driver and load-data scoreboard.
`timescale 1ns/1ps
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_Flush, MEM_Valid, MEM_IsLoad, MEM_IsStore, MEM_LoadSign;
   logic [31:0] MEM_ALUOut, MEM_OutB;
   logic [1:0]  MEM_Size, MEM_LWLR;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic [31:0] MEM_LoadData, MEM_BadVAddr;
   logic        MEM_Stall, MEM_AdEL, MEM_AdES;
   logic [2:0]  dbg_state;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_load;

   int          req_cyc, stall_cyc;
   logic        stable, done, f_wr;
   logic [31:0] f_addr, f_wdata;
   logic [3:0]  f_wstrb;
   logic [1:0]  f_size;
   logic        exp_adel;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .MEM_Flush(MEM_Flush), .MEM_Valid(MEM_Valid), .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
      .MEM_IsLoad(MEM_IsLoad), .MEM_IsStore(MEM_IsStore), .MEM_Size(MEM_Size),
      .MEM_LoadSign(MEM_LoadSign), .MEM_LWLR(MEM_LWLR),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .MEM_LoadData(MEM_LoadData), .MEM_Stall(MEM_Stall), .MEM_AdEL(MEM_AdEL),
      .MEM_AdES(MEM_AdES), .MEM_BadVAddr(MEM_BadVAddr), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      logic [31:0] exp;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=0x%08h expected=<nothing queued>", tag, MEM_LoadData);
      end else begin
         exp = exp_q.pop_front();
         last_load = exp;
         check(tag, MEM_LoadData, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic drive_idle();
      MEM_Flush = 1'b0; MEM_Valid = 1'b0; MEM_IsLoad = 1'b0; MEM_IsStore = 1'b0;
      MEM_Size = 2'd0; MEM_LoadSign = 1'b0; MEM_LWLR = 2'b00;
      MEM_ALUOut = 32'h0; MEM_OutB = 32'h0;
   endtask

   task automatic drive_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                             input logic [1:0] lwlr, input logic [31:0] outb);
      MEM_Flush = 1'b0; MEM_Valid = 1'b1; MEM_IsLoad = 1'b1; MEM_IsStore = 1'b0;
      MEM_Size = size; MEM_LoadSign = sgn; MEM_LWLR = lwlr;
      MEM_ALUOut = addr; MEM_OutB = outb;
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] outb);
      MEM_Flush = 1'b0; MEM_Valid = 1'b1; MEM_IsLoad = 1'b0; MEM_IsStore = 1'b1;
      MEM_Size = size; MEM_LoadSign = 1'b0; MEM_LWLR = 2'b00;
      MEM_ALUOut = addr; MEM_OutB = outb;
   endtask

   // Bus slave: accepts after aok_dly request cycles, answers dok_dly cycles after acceptance.
   // Called at posedge+1 with the instruction driven; returns at posedge+2 of the DONE cycle.
   task automatic bus_access(input int aok_dly, input int dok_dly, input logic [31:0] rdata,
                             output int rq, output int st, output logic stab,
                             output logic [31:0] a0, output logic [3:0] s0, output logic [31:0] w0,
                             output logic wr0, output logic [1:0] z0, output logic fin);
      int phase;
      int cnt;
      phase = 0; cnt = 0; rq = 0; st = 0; stab = 1'b1; fin = 1'b0;
      a0 = 32'h0; s0 = 4'h0; w0 = 32'h0; wr0 = 1'b0; z0 = 2'd0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (phase == 2 && !MEM_Stall) begin
            fin = 1'b1;
            break;
         end
         if (MEM_Stall) st++;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         if (phase == 0) begin
            if (data_req) begin
               if (rq == 0) begin
                  a0 = data_addr; s0 = data_wstrb; w0 = data_wdata; wr0 = data_wr; z0 = data_size;
               end else if (data_addr !== a0) begin
                  stab = 1'b0;
               end
               rq++;
               if (cnt == aok_dly) begin
                  data_addr_ok = 1'b1;
                  phase = 1;
                  cnt = 0;
               end else begin
                  cnt++;
               end
            end
         end else if (phase == 1) begin
            if (cnt == dok_dly) begin
               data_data_ok = 1'b1;
               data_rdata = rdata;
               phase = 2;
            end else begin
               cnt++;
            end
         end
         @(posedge clk);
         #1;
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      last_load = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_req", data_req, 1'b0);
      check("rst_stall", MEM_Stall, 1'b0);
      check("rst_adel", MEM_AdEL, 1'b0);
      check("rst_ades", MEM_AdES, 1'b0);
      check("rst_loaddata", MEM_LoadData, 32'h0);
      check("rst_state_idle", dbg_state, 3'd0);
      rst = 1'b0;
      step();

      // lw with addr_ok delayed two cycles
      drive_load(32'h8000_1004, 2'd2, 1'b0, 2'b00, 32'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      bus_access(2, 0, 32'hDEAD_BEEF, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lw_done", done, 1'b1);
      check("lw_req_cycles", req_cyc, 3);
      check("lw_addr_stable", stable, 1'b1);
      check("lw_addr", f_addr, 32'h8000_1004);
      check("lw_wstrb", f_wstrb, 4'b0000);
      check("lw_wr", f_wr, 1'b0);
      check("lw_stall_cycles", stall_cyc, 4);
      sb_check("lw_data");

      // sb lane formatting
      step();
      drive_store(32'h8000_0003, 2'd0, 32'h1234_5678);
      bus_access(0, 0, 32'h0, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("sb_done", done, 1'b1);
      check("sb_wstrb", f_wstrb, 4'b1000);
      check("sb_wdata", f_wdata, 32'h7878_7878);
      check("sb_wr", f_wr, 1'b1);
      check("sb_size", f_size, 2'd0);
      check("sb_stall_cycles", stall_cyc, 2);

      // sh upper half
      step();
      drive_store(32'h8000_0002, 2'd1, 32'hAAAA_5678);
      bus_access(1, 0, 32'h0, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("sh_done", done, 1'b1);
      check("sh_wstrb", f_wstrb, 4'b1100);
      check("sh_wdata", f_wdata, 32'h5678_5678);
      check("sh_size", f_size, 2'd1);
      check("sh_stall_cycles", stall_cyc, 3);

      // misaligned lh
      step();
      drive_load(32'h8000_0001, 2'd1, 1'b0, 2'b00, 32'h0);
      #1;
      check("lh_mis_adel", MEM_AdEL, 1'b1);
      check("lh_mis_ades", MEM_AdES, 1'b0);
      check("lh_mis_badvaddr", MEM_BadVAddr, 32'h8000_0001);
      check("lh_mis_req", data_req, 1'b0);
      check("lh_mis_stall", MEM_Stall, 1'b0);
      step();
      #1;
      check("lh_mis_req_next", data_req, 1'b0);

      // misaligned sw
      step();
      drive_store(32'h8000_0006, 2'd2, 32'h0);
      #1;
      check("sw_mis_ades", MEM_AdES, 1'b1);
      check("sw_mis_adel", MEM_AdEL, 1'b0);
      check("sw_mis_req", data_req, 1'b0);

      // unaligned word carrying an LWL code
`ifdef MEM_LWLR_EN
      exp_adel = 1'b0;
`else
      exp_adel = 1'b1;
`endif
      step();
      drive_load(32'h8000_0003, 2'd2, 1'b0, 2'b01, 32'h0);
      #1;
      check("lwl_code_adel", MEM_AdEL, exp_adel);
      #1;
      drive_idle();

      // lb signed / unsigned, lane 2
      step();
      drive_load(32'h8000_0002, 2'd0, 1'b1, 2'b00, 32'h0);
      exp_q.push_back(32'hFFFF_FF80);
      bus_access(0, 0, 32'h0080_0000, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lb_done", done, 1'b1);
      check("lb_best_stall", stall_cyc, 2);
      sb_check("lb_signed");
      step();
      drive_load(32'h8000_0002, 2'd0, 1'b0, 2'b00, 32'h0);
      exp_q.push_back(32'h0000_0080);
      bus_access(0, 1, 32'h0080_0000, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lbu_done", done, 1'b1);
      check("lbu_stall", stall_cyc, 3);
      sb_check("lb_unsigned");

      // half loads
      step();
      drive_load(32'h8000_0002, 2'd1, 1'b0, 2'b00, 32'h0);
      exp_q.push_back(32'h0000_BEEF);
      bus_access(1, 2, 32'hBEEF_1234, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lhu_done", done, 1'b1);
      check("lhu_stall", stall_cyc, 5);
      sb_check("lhu_data");
      step();
      drive_load(32'h8000_0000, 2'd1, 1'b1, 2'b00, 32'h0);
      exp_q.push_back(32'hFFFF_8001);
      bus_access(0, 0, 32'h1234_8001, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lh_done", done, 1'b1);
      sb_check("lh_signed");

      // flush while waiting for data, next load must wait for the drain
      step();
      drive_load(32'h8000_2000, 2'd2, 1'b0, 2'b00, 32'h0);
      #1;
      check("flush_first_req", data_req, 1'b1);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      MEM_Flush = 1'b1;
      #1;
      check("flush_wait_stall", MEM_Stall, 1'b1);
      step();
      drive_load(32'h8000_2010, 2'd2, 1'b0, 2'b00, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("drain_no_req_%0d", i), data_req, 1'b0);
         check($sformatf("drain_stall_%0d", i), MEM_Stall, 1'b1);
         if (i == 2) begin
            data_data_ok = 1'b1;
            data_rdata = 32'h1111_1111;
         end
         step();
      end
      data_data_ok = 1'b0;
      #1;
      check("drain_loaddata_hold", MEM_LoadData, last_load);
      exp_q.push_back(32'hCAFE_F00D);
      bus_access(0, 0, 32'hCAFE_F00D, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("after_drain_done", done, 1'b1);
      check("after_drain_addr", f_addr, 32'h8000_2010);
      check("after_drain_req_cycles", req_cyc, 1);
      sb_check("after_drain_data");

      // reset while a load is outstanding
      step();
      drive_load(32'h8000_3000, 2'd2, 1'b0, 2'b00, 32'h0);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive_idle();
      #1;
      check("midrst_stall", MEM_Stall, 1'b0);
      check("midrst_req", data_req, 1'b0);
      check("midrst_loaddata", MEM_LoadData, 32'h0);
      check("midrst_state_idle", dbg_state, 3'd0);

`ifdef MEM_LWLR_EN
      step();
      drive_load(32'h8000_0011, 2'd2, 1'b0, 2'b01, 32'h1122_3344);
      exp_q.push_back(32'hCCDD_3344);
      bus_access(0, 0, 32'hAABB_CCDD, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lwl_done", done, 1'b1);
      check("lwl_addr", f_addr, 32'h8000_0010);
      check("lwl_size", f_size, 2'd2);
      sb_check("lwl_data");
      step();
      drive_load(32'h8000_0011, 2'd2, 1'b0, 2'b10, 32'h1122_3344);
      exp_q.push_back(32'h11AA_BBCC);
      bus_access(0, 0, 32'hAABB_CCDD, req_cyc, stall_cyc, stable, f_addr, f_wstrb, f_wdata, f_wr, f_size, done);
      check("lwr_done", done, 1'b1);
      sb_check("lwr_data");
`endif

      step();
      drive_idle();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register. It consumes the registered address, store data and access type, checks alignment, and issues one request at a time on an SRAM-like data bus (req/addr_ok/data_ok). It stalls the pipeline until the access completes, then returns aligned and extended load data to the MEM/WB path. Flushes that arrive while a bus transaction is outstanding are drained safely.

## Interface
Parameters: none.

Ports. Clock `clk`, one clock domain. Reset `rst`, synchronous, active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MEM_Flush  in  1  kill the instruction currently in MEM
- MEM_Valid  in  1  MEM holds a live instruction with no prior exception
- MEM_ALUOut  in  32  effective address
- MEM_OutB  in  32  store data / old rt value (for merge)
- MEM_IsLoad, MEM_IsStore  in  1 each  access kind; mutually exclusive
- MEM_Size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- MEM_LoadSign  in  1  sign-extend byte/half loads
- MEM_LWLR  in  2  00=none, 01=LWL, 10=LWR (used only with MEM_LWLR_EN)
- data_req  out  1  bus request
- data_wr  out  1  1=store
- data_size  out  2  bus size
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/write done
- data_rdata  in  32  read data
- MEM_LoadData  out  32  aligned and extended load result
- MEM_Stall  out  1  hold the pipeline at MEM and above
- MEM_AdEL, MEM_AdES  out  1 each  load/store address error
- MEM_BadVAddr  out  32  faulting address

## Operation
- Access is requested when `acc = MEM_Valid & (MEM_IsLoad|MEM_IsStore) & aligned & !MEM_Flush`.
- Alignment rules:
  - half requires addr[0]=0
  - word requires addr[1:0]=0
  - LWL/LWR always aligned when enabled
- A misaligned access:
  - asserts MEM_AdEL (load) or MEM_AdES (store) combinationally
  - drives MEM_BadVAddr = MEM_ALUOut
  - issues no request and no stall
- Store formatting:
  - byte: wstrb = 1<<addr[1:0], wdata = {4{OutB[7:0]}}
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{OutB[15:0]}}
  - word: wstrb = 1111, wdata = OutB
  - Loads drive wstrb = 0000.
- Load extraction:
  - byte/half lane is selected by addr[1:0]
  - zero- or sign-extended per MEM_LoadSign
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - data_req = acc, with address and controls taken combinationally from the inputs
  - acc & addr_ok → WAIT
  - acc & !addr_ok → REQ; address and controls are latched and held stable
- REQ:
  - data_req = 1 from the latched values
  - addr_ok → WAIT, or DRAIN if a flush is pending
  - A flush is recorded in a sticky bit; an issued req is never withdrawn
- WAIT:
  - data_ok → DONE, with the formatted load result registered
  - MEM_Flush (or the sticky flush bit) → DRAIN
  - data_ok together with flush → IDLE, result discarded
- DONE:
  - one cycle; MEM_Stall = 0; MEM_LoadData is valid from the register
  - → IDLE
  - Flush in DONE → IDLE; the result is ignored downstream
- DRAIN:
  - waits for data_ok, discards the response, then → IDLE
  - MEM_Stall = MEM_Valid & (IsLoad|IsStore), so a new access waits
- MEM_Stall = 1 in IDLE when acc, in REQ, and in WAIT; 0 in DONE.
- Only one outstanding transaction at any time.

## Timing
- Reset values: state = IDLE, sticky flush = 0, latched controls = 0, MEM_LoadData = 0.
- Combinational outputs at reset: data_req = 0, MEM_Stall = 0, MEM_AdEL = 0, MEM_AdES = 0.
- Best-case latency (addr_ok in the request cycle, data_ok next cycle):
  - stall high for 2 cycles; data valid in cycle 3 (DONE)
- Each extra cycle of addr_ok or data_ok delay adds one stall cycle.
- Reset mid-operation returns to IDLE immediately; the bus slave is reset in the same cycle.
- MEM_LoadData holds its value outside DONE.

## Configuration
- `MEM_LWLR_EN` defined (LWL/LWR support):
  - bus address = addr & ~3, size = word
  - k = addr[1:0]
  - LWL result = (rdata << 8·(3−k)) | (OutB & (2^(8·(3−k)) − 1))
  - LWR result = (rdata >> 8k) | (OutB & ~(2^(32−8k) − 1)), keeping OutB's top 8k bits
- Undefined:
  - MEM_LWLR is ignored
  - the access behaves as a normal load per MEM_Size, so an unaligned word raises AdEL

## Test plan
- lw at 0x80001004, addr_ok delayed 2 cycles, rdata 0xDEADBEEF → data_req held 3 cycles with a stable address, stall for 4 cycles, MEM_LoadData = 0xDEADBEEF.
- sb at 0x80000003, OutB 0x12345678 → wstrb 1000, wdata 0x78787878, data_wr = 1.
- lh at 0x80000001 → MEM_AdEL = 1, BadVAddr 0x80000001, no data_req, no stall.
- lb signed at addr[1:0]=2, rdata 0x00800000 → MEM_LoadData = 0xFFFFFF80; unsigned → 0x00000080.
- MEM_Flush in WAIT, data_ok 3 cycles later while a new lw is valid → DRAIN, first response discarded, second request issued only after data_ok.
- With MEM_LWLR_EN: LWL at addr[1:0]=1, rdata 0xAABBCCDD, OutB 0x11223344 → 0xCCDD3344.
